particle_record_assembler: RTL and testbench

PARTICLE_RECORD_ASSEMBLER -- requirements
Module: particle_record_assembler

---
 rtl/particle_record_assembler.sv | 192 +++++++++++++++++++
 tb/tb_particle_record_assembler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/particle_record_assembler.sv
// particle_record_assembler
// Collects particle payload bytes from the message receiver, packs them
// little-endian into fixed-size records and writes each completed record
// into the next slot of the downstream particle RAM. At each frame end it
// reports how many records were written. Two sticky flags report dropped
// records (RAM full) and a trailing partial record.

module particle_record_assembler #(
  parameter int BYTES_PER_RECORD = 8,
  parameter int MAX_PARTICLES    = 16,
  parameter int ADDR_W           = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          particle_flag,
  input  logic                          map_flag,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [8*BYTES_PER_RECORD-1:0] wr_data,
  output logic [ADDR_W:0]               particle_count,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          short_record
);

  localparam int REC_W = 8 * BYTES_PER_RECORD;
  localparam int IDX_W = (BYTES_PER_RECORD > 1) ? $clog2(BYTES_PER_RECORD) : 1;

  localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W+1)'(MAX_PARTICLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_PARTICLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_RECORD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_END     = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 flag_prev_reg, flag_prev_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [REC_W-1:0]     asm_reg, asm_next;
  logic [ADDR_W:0]      rec_count_reg, rec_count_next;
  logic                 wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]    wr_addr_reg, wr_addr_next;
  logic [REC_W-1:0]     wr_data_reg, wr_data_next;
  logic [ADDR_W:0]      particle_count_reg, particle_count_next;
  logic                 overflow_reg, overflow_next;
  logic                 short_reg, short_next;

  logic                 accept;
  logic                 flag_rise;
  logic                 rec_last;
  logic [ADDR_W:0]      eff_count;
  logic [REC_W-1:0]     rec_filled;

  // A byte counts only while collecting particle payload with no map payload.
  assign accept    = (state_reg == S_COLLECT) && rx_valid && particle_flag && !map_flag;
  assign flag_rise = particle_flag && !flag_prev_reg;
  assign rec_last  = accept && (idx_reg == LAST_IDX);

  // Records already written plus a write still being presented on the port;
  // this is the true occupancy when deciding on a new write or latching the
  // frame count.
  assign eff_count = rec_count_reg + {{ADDR_W{1'b0}}, wr_en_reg};

  // Byte lanes: the incoming byte lands in the lane selected by the byte
  // index, every other lane keeps what was already collected.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_RECORD; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit = accept && (idx_reg == IDX_W'(gi));
      assign rec_filled[8*gi +: 8] = lane_hit ? rx_data : asm_reg[8*gi +: 8];
    end
  endgenerate

  // Next-state, record assembly, write scheduling and frame reporting.
  always_comb begin
    state_next          = state_reg;
    flag_prev_next      = particle_flag;
    idx_next            = idx_reg;
    asm_next            = asm_reg;
    rec_count_next      = rec_count_reg;
    wr_en_next          = 1'b0;
    wr_addr_next        = wr_addr_reg;
    wr_data_next        = wr_data_reg;
    particle_count_next = particle_count_reg;
    overflow_next       = overflow_reg;
    short_next          = short_reg;

    // Retire the write presented this cycle: advance count and slot, but
    // never wrap the slot past the last RAM entry.
    if (wr_en_reg) begin
      rec_count_next = rec_count_reg + (ADDR_W+1)'(1);
      if (wr_addr_reg != LAST_ADDR) begin
        wr_addr_next = wr_addr_reg + ADDR_W'(1);
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (flag_rise) begin
          state_next     = S_COLLECT;
          idx_next       = '0;
          asm_next       = '0;
          wr_addr_next   = '0;
          rec_count_next = '0;
          overflow_next  = 1'b0;
          short_next     = 1'b0;
        end
      end

      S_COLLECT: begin
        if (!particle_flag) begin
          // Frame end: a write still on the port is included in the count,
          // and any partially collected record is dropped.
          state_next          = S_END;
          particle_count_next = eff_count;
          short_next          = (idx_reg != '0);
          idx_next            = '0;
        end else if (accept) begin
          asm_next = rec_filled;
          if (rec_last) begin
            idx_next = '0;
            if (eff_count < MAX_CNT) begin
              wr_en_next   = 1'b1;
              wr_data_next = rec_filled;
            end else begin
              overflow_next = 1'b1;
            end
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end

      S_END: begin
        // Hold the previous flag sample so a rise seen during this cycle is
        // still detected as an edge on the following idle cycle.
        state_next     = S_IDLE;
        flag_prev_next = flag_prev_reg;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      // Treat the flag as already high so a flag held through reset does
      // not restart a frame; a fresh rising edge is required.
      flag_prev_reg      <= 1'b1;
      idx_reg            <= '0;
      asm_reg            <= '0;
      rec_count_reg      <= '0;
      wr_en_reg          <= 1'b0;
      wr_addr_reg        <= '0;
      wr_data_reg        <= '0;
      particle_count_reg <= '0;
      overflow_reg       <= 1'b0;
      short_reg          <= 1'b0;
    end else begin
      state_reg          <= state_next;
      flag_prev_reg      <= flag_prev_next;
      idx_reg            <= idx_next;
      asm_reg            <= asm_next;
      rec_count_reg      <= rec_count_next;
      wr_en_reg          <= wr_en_next;
      wr_addr_reg        <= wr_addr_next;
      wr_data_reg        <= wr_data_next;
      particle_count_reg <= particle_count_next;
      overflow_reg       <= overflow_next;
      short_reg          <= short_next;
    end
  end

  assign wr_en          = wr_en_reg;
  assign wr_addr        = wr_addr_reg;
  assign wr_data        = wr_data_reg;
  assign particle_count = particle_count_reg;
  assign frame_done     = (state_reg == S_END);
  assign overflow       = overflow_reg;
  assign short_record   = short_reg;

endmodule

// File: tb/tb_particle_record_assembler.sv
// Testbench for particle_record_assembler: directed frames, expected RAM
// writes and frame reports queued by the stimulus, checked by a monitor.

module tb_particle_record_assembler;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        particle_flag;
  logic        map_flag;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  particle_count;
  logic        frame_done;
  logic        overflow;
  logic        short_record;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] data;
  } wexp_t;

  typedef struct {
    logic [4:0] cnt;
    logic       ov;
    logic       sh;
  } fexp_t;

  wexp_t wr_q[$];
  fexp_t fr_q[$];

  particle_record_assembler #(
    .BYTES_PER_RECORD(8),
    .MAX_PARTICLES(16),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .particle_flag(particle_flag),
    .map_flag(map_flag),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .particle_count(particle_count),
    .frame_done(frame_done),
    .overflow(overflow),
    .short_record(short_record)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: compare each presented write / frame report with the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_wr_en", {60'd0, wr_addr}, 64'hFFFF);
        end else begin
          wexp_t w;
          w = wr_q.pop_front();
          chk("wr_addr", {60'd0, wr_addr}, {60'd0, w.addr});
          chk("wr_data", wr_data, w.data);
        end
      end
      if (frame_done) begin
        chk("writes_pending_at_done", 64'(wr_q.size()), 64'd0);
        if (fr_q.size() == 0) begin
          chk("unexpected_frame_done", {59'd0, particle_count}, 64'hFFFF);
        end else begin
          fexp_t f;
          f = fr_q.pop_front();
          chk("particle_count", {59'd0, particle_count}, {59'd0, f.cnt});
          chk("overflow", {63'd0, overflow}, {63'd0, f.ov});
          chk("short_record", {63'd0, short_record}, {63'd0, f.sh});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic mf);
    rx_data  = b;
    rx_valid = 1'b1;
    map_flag = mf;
    cyc();
    rx_valid = 1'b0;
    map_flag = 1'b0;
  endtask

  task automatic start_frame();
    particle_flag = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic end_frame();
    particle_flag = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [63:0] d);
    wexp_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_fr(input logic [4:0] c, input logic ov, input logic sh);
    fexp_t f;
    f.cnt = c;
    f.ov  = ov;
    f.sh  = sh;
    fr_q.push_back(f);
  endtask

  initial begin
    logic [63:0] rec;
    reset         = 1'b1;
    rx_data       = 8'h00;
    rx_valid      = 1'b0;
    particle_flag = 1'b0;
    map_flag      = 1'b0;
    cyc();
    cyc();

    // Reset state.
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", {60'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_particle_count", {59'd0, particle_count}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_short_record", {63'd0, short_record}, 64'd0);
    reset = 1'b0;
    cyc();

    // Two records, last byte accepted right before the flag falls.
    push_wr(4'd0, 64'h0807060504030201);
    push_wr(4'd1, 64'h100F0E0D0C0B0A09);
    push_fr(5'd2, 1'b0, 1'b0);
    start_frame();
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0);
    end_frame();

    // Partial record: 11 bytes.
    push_wr(4'd0, 64'hB7B6B5B4B3B2B1B0);
    push_fr(5'd1, 1'b0, 1'b1);
    start_frame();
    for (int i = 0; i < 11; i++) send_byte(8'(8'hB0 + i), 1'b0);
    end_frame();
    repeat (3) cyc();
    chk("short_record_held", {63'd0, short_record}, 64'd1);
    chk("particle_count_held", {59'd0, particle_count}, 64'd1);

    // Filtering: map-only bytes outside a frame, both-flag bytes inside.
    for (int i = 0; i < 3; i++) send_byte(8'h55, 1'b1);
    push_fr(5'd0, 1'b0, 1'b0);
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(8'h66, 1'b1);
    end_frame();

    // Both-flag bytes interleaved inside a record leave the index alone.
    push_wr(4'd0, 64'h1716151413121110);
    push_fr(5'd1, 1'b0, 1'b0);
    start_frame();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b0);
    send_byte(8'hEE, 1'b1);
    send_byte(8'hEF, 1'b1);
    for (int i = 3; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
    end_frame();

    // Overflow: 17 full records, only 16 written.
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 8; k++) rec[8*k +: 8] = 8'(r * 16 + k);
      push_wr(4'(r), rec);
    end
    push_fr(5'd16, 1'b1, 1'b0);
    start_frame();
    for (int r = 0; r < 17; r++)
      for (int k = 0; k < 8; k++) send_byte(8'(r * 16 + k), 1'b0);
    end_frame();
    chk("overflow_held", {63'd0, overflow}, 64'd1);
    chk("wr_addr_saturated", {60'd0, wr_addr}, 64'd15);

    // Reset mid-frame aborts it; the flag held through reset is no new edge.
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b0);
    reset = 1'b1;
    cyc();
    cyc();
    chk("abort_wr_addr", {60'd0, wr_addr}, 64'd0);
    chk("abort_overflow", {63'd0, overflow}, 64'd0);
    reset = 1'b0;
    send_byte(8'hDD, 1'b0);
    send_byte(8'hDD, 1'b0);
    end_frame();
    push_wr(4'd0, 64'hA7A6A5A4A3A2A1A0);
    push_fr(5'd1, 1'b0, 1'b0);
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
    end_frame();

    repeat (5) cyc();
    chk("writes_outstanding", 64'(wr_q.size()), 64'd0);
    chk("frames_outstanding", 64'(fr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
